program_counter_ras: RTL and testbench
======================================

Name: program_counter_ras

Overview:
- Parametrised successor to the single-register program counter.
- Computes and registers the next fetch address internally instead of taking a ready-made next address.
- Next-address sources: sequential increment, PC-relative branch, absolute jump, call and return.
- Call/return targets come from an internal circular return-address stack (RAS); a stall input freezes the fetch address for the pipeline front end.

Parameters:
WIDTH, 32, address width in bits
RESET_ADDR, 32'h0000_0000, value of currentAddress after reset
INC, 4, sequential increment in bytes
RAS_DEPTH, 4, return-address stack entries (power of 2, >= 2)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  hold PC and RAS; all other requests ignored
branch_taken  in  1  take PC-relative branch
branch_offset  in  WIDTH  two's-complement byte offset added to currentAddress
jump  in  1  absolute jump to jump_target
call  in  1  absolute jump to jump_target and push return address
jump_target  in  WIDTH  target for jump/call
ret  in  1  pop RAS and jump to the popped address
currentAddress  out  WIDTH  registered fetch address
ras_empty  out  1  combinational: RAS holds 0 entries
ras_full  out  1  combinational: RAS holds RAS_DEPTH entries
ras_overflow  out  1  registered one-cycle pulse: a call overwrote the oldest entry
ras_underflow  out  1  registered one-cycle pulse: a ret found the RAS empty

Behaviour:
- Reset (rst=0, asynchronous, independent of clk): currentAddress=RESET_ADDR, RAS count=0, top pointer=0, ras_overflow=0, ras_underflow=0.
- Reset asserted mid-operation discards pending requests. The first rising edge with rst=1 applies that cycle's inputs normally.
- Latency: inputs sampled at a rising edge; the new currentAddress is visible after that edge (1 cycle).
- Arithmetic: all sums are modulo 2^WIDTH. No alignment forcing; odd addresses pass through unchanged.
- Sequential value seq = currentAddress + INC.
- Per-edge priority when stall=0, highest first:
  1. ret: if count>0, next = RAS[top], pop (count-1). If count=0, next = seq and ras_underflow=1 for one cycle.
  2. call: next = jump_target; push seq. If count=RAS_DEPTH, the oldest entry is overwritten, count stays RAS_DEPTH, ras_overflow=1 for one cycle.
  3. jump: next = jump_target.
  4. branch_taken: next = currentAddress + branch_offset.
  5. otherwise: next = seq.
- When ret and call are asserted together, ret wins and the call is ignored: no push, no overflow.
- jump or branch_taken asserted together with a higher-priority request are ignored.
- stall=1: currentAddress, RAS contents, count and pointer are all held. Both pulse flags are 0 on that edge.
- The RAS is a circular buffer indexed by a log2(RAS_DEPTH)-bit top pointer; pointer arithmetic wraps.
- The pulse flags clear on the next non-reset edge unless re-triggered.

Test Plan:
- Reset and increment: hold rst=0 then release, no requests, 4 edges -> currentAddress 0x0, 0x4, 0x8, 0xC, 0x10. Assert rst=0 between clock edges -> currentAddress becomes 0x0 immediately.
- Wrap and branch: jump to 0xFFFFFFFC, then 1 idle edge -> 0x00000000. From 0x100, branch_offset=0xFFFFFFF0 -> 0xF0. Same cycle with jump=1, jump_target=0x2000 -> 0x2000 (jump wins over branch).
- Call/return: at 0x40, call with jump_target=0x800 -> PC 0x800, ras_empty=0. 2 idle edges -> 0x808. ret -> 0x44, ras_empty=1.
- Overflow: 5 nested calls from PCs 0x0, 0x10, 0x20, 0x30, 0x40 (each jump_target = current PC + 0x10). The 5th call pulses ras_overflow=1 with ras_full=1. 4 rets return 0x44, 0x34, 0x24, 0x14. A 5th ret pulses ras_underflow=1 and gives PC = previous PC + 4.
- Stall and simultaneity: with PC 0x200 and stall=1 plus call=1 for 3 edges -> PC stays 0x200, RAS unchanged. Then stall=0 with call=1 and ret=1 on an empty RAS -> PC 0x204, ras_underflow=1, ras_empty stays 1.

Source files
------------

// File: rtl/program_counter_ras.sv
// Fetch-address generator with sequential/branch/jump/call/return sources
// and a circular return-address stack that overwrites its oldest entry when full.
module program_counter_ras #(
    parameter int unsigned       WIDTH      = 32,
    parameter logic [WIDTH-1:0]  RESET_ADDR = '0,
    parameter int unsigned       INC        = 4,
    parameter int unsigned       RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic             call,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             ret,
    output logic [WIDTH-1:0] currentAddress,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] next_addr;
    logic [PTR_W-1:0] next_top;
    logic [CNT_W-1:0] next_count;
    logic             push_en;
    logic             next_overflow;
    logic             next_underflow;

    assign seq       = currentAddress + WIDTH'(INC);
    assign ras_empty = (count == '0);
    assign ras_full  = (count == CNT_W'(RAS_DEPTH));

    // Next-address selection: ret > call > jump > branch > sequential.
    always_comb begin
        next_addr      = seq;
        next_top       = top;
        next_count     = count;
        push_en        = 1'b0;
        next_overflow  = 1'b0;
        next_underflow = 1'b0;
        if (stall) begin
            next_addr = currentAddress;
        end else if (ret) begin
            if (count != '0) begin
                next_addr  = ras[top];
                next_top   = top - PTR_W'(1);
                next_count = count - CNT_W'(1);
            end else begin
                next_underflow = 1'b1;
            end
        end else if (call) begin
            next_addr = jump_target;
            push_en   = 1'b1;
            next_top  = top + PTR_W'(1);
            if (count == CNT_W'(RAS_DEPTH)) begin
                // Pointer wrap lands on the oldest entry, which the push replaces.
                next_overflow = 1'b1;
            end else begin
                next_count = count + CNT_W'(1);
            end
        end else if (jump) begin
            next_addr = jump_target;
        end else if (branch_taken) begin
            next_addr = currentAddress + branch_offset;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            currentAddress <= RESET_ADDR;
            top            <= '0;
            count          <= '0;
            ras_overflow   <= 1'b0;
            ras_underflow  <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras[i] <= '0;
            end
        end else begin
            currentAddress <= next_addr;
            top            <= next_top;
            count          <= next_count;
            ras_overflow   <= next_overflow;
            ras_underflow  <= next_underflow;
            if (push_en) begin
                ras[next_top] <= seq;
            end
        end
    end

endmodule

// File: tb/tb_program_counter_ras.sv
// Directed plus random stimulus for program_counter_ras, checked against a
// queue-based model of the fetch address and return-address stack.
module tb_program_counter_ras;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic        call;
    logic [31:0] jump_target;
    logic        ret;
    logic [31:0] currentAddress;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_overflow;
    logic        ras_underflow;

    program_counter_ras #(
        .WIDTH     (32),
        .RESET_ADDR(32'h0000_0000),
        .INC       (4),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .call          (call),
        .jump_target   (jump_target),
        .ret           (ret),
        .currentAddress(currentAddress),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    int unsigned total  = 0;
    int unsigned passed = 0;

    // Reference model state
    logic [31:0] mpc;
    logic [31:0] mq[$];
    logic        movf;
    logic        mudf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mpc  = 32'h0;
        mq.delete();
        movf = 1'b0;
        mudf = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic br, input logic [31:0] off,
                              input logic j, input logic c, input logic [31:0] t,
                              input logic r);
        logic [31:0] nxt;
        movf = 1'b0;
        mudf = 1'b0;
        if (s) return;
        nxt = mpc + 32'd4;
        if (r) begin
            if (mq.size() > 0) nxt = mq.pop_back();
            else mudf = 1'b1;
        end else if (c) begin
            if (mq.size() == DEPTH) begin
                void'(mq.pop_front());
                movf = 1'b1;
            end
            mq.push_back(mpc + 32'd4);
            nxt = t;
        end else if (j) begin
            nxt = t;
        end else if (br) begin
            nxt = mpc + off;
        end
        mpc = nxt;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    currentAddress,        mpc);
        check({tag, ".empty"}, 32'(ras_empty),        32'(mq.size() == 0));
        check({tag, ".full"},  32'(ras_full),         32'(mq.size() == DEPTH));
        check({tag, ".ovf"},   32'(ras_overflow),     32'(movf));
        check({tag, ".udf"},   32'(ras_underflow),    32'(mudf));
    endtask

    task automatic step(input string tag, input logic s, input logic br, input logic [31:0] off,
                        input logic j, input logic c, input logic [31:0] t, input logic r);
        stall = s; branch_taken = br; branch_offset = off;
        jump = j; call = c; jump_target = t; ret = r;
        model_step(s, br, off, j, c, t, r);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_jump(input string tag, input logic [31:0] t);
        step(tag, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, t, 1'b0);
    endtask

    task automatic do_call(input string tag, input logic [31:0] t);
        step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, t, 1'b0);
    endtask

    task automatic do_ret(input string tag);
        step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        jump = 1'b0; call = 1'b0; jump_target = '0; ret = 1'b0;
        model_reset();

        // Reset and increment
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle("inc1"); check("inc1.const", currentAddress, 32'h4);
        idle("inc2"); check("inc2.const", currentAddress, 32'h8);
        idle("inc3"); check("inc3.const", currentAddress, 32'hC);
        idle("inc4"); check("inc4.const", currentAddress, 32'h10);

        // Asynchronous reset between edges
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst = 1'b1;

        // Wrap and branch
        do_jump("jmp_top", 32'hFFFF_FFFC);
        idle("wrap"); check("wrap.const", currentAddress, 32'h0);
        do_jump("jmp_100", 32'h100);
        step("branch_neg", 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("branch_neg.const", currentAddress, 32'hF0);
        step("jmp_over_br", 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0, 32'h2000, 1'b0);
        check("jmp_over_br.const", currentAddress, 32'h2000);

        // Call / return
        do_jump("jmp_40", 32'h40);
        do_call("call_800", 32'h800);
        check("call_800.empty", 32'(ras_empty), 32'h0);
        idle("cr_idle1");
        idle("cr_idle2"); check("cr_idle2.const", currentAddress, 32'h808);
        do_ret("ret_44"); check("ret_44.const", currentAddress, 32'h44);
        check("ret_44.empty", 32'(ras_empty), 32'h1);

        // Overflow / underflow
        do_jump("jmp_0", 32'h0);
        for (int i = 0; i < 5; i++) do_call($sformatf("ncall%0d", i), currentAddress + 32'h10);
        check("ovf.pulse", 32'(ras_overflow), 32'h1);
        check("ovf.full",  32'(ras_full),     32'h1);
        do_ret("nret0"); check("nret0.const", currentAddress, 32'h44);
        do_ret("nret1"); check("nret1.const", currentAddress, 32'h34);
        do_ret("nret2"); check("nret2.const", currentAddress, 32'h24);
        do_ret("nret3"); check("nret3.const", currentAddress, 32'h14);
        do_ret("nret4");
        check("udf.pulse", 32'(ras_underflow), 32'h1);
        check("udf.pc",    currentAddress,     32'h18);
        idle("udf_clear");

        // Stall and simultaneous call/ret
        do_jump("jmp_200", 32'h200);
        for (int i = 0; i < 3; i++)
            step($sformatf("stall%0d", i), 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h900, 1'b0);
        check("stall.const", currentAddress, 32'h200);
        step("call_ret", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h900, 1'b1);
        check("call_ret.pc",    currentAddress,        32'h204);
        check("call_ret.udf",   32'(ras_underflow),    32'h1);
        check("call_ret.empty", 32'(ras_empty),        32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic s, br, j, c, r;
            logic [31:0] off, t;
            s   = ($urandom_range(0, 7) == 0);
            r   = ($urandom_range(0, 3) == 0);
            c   = ($urandom_range(0, 3) == 0);
            j   = ($urandom_range(0, 7) == 0);
            br  = ($urandom_range(0, 3) == 0);
            off = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 255)) - 32'd128;
            t   = $urandom();
            step($sformatf("rnd%0d", n), s, br, off, j, c, t, r);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
